// File: rtl/regtrace_collector.sv
// Packs multi-beat commit records into single register-writeback trace records
// and drains them one per cycle. Define REGTRACE_STALL_CNT_EN to add stall/occupancy counters.
module regtrace_collector #(
   parameter int ARCH_LEN  = 32,
   parameter int NUM_WARPS = 8,
   parameter int NUM_LANES = 16,
   parameter int REG_BITS  = 8,
   parameter int DEPTH     = 4,
   localparam int WARP_ID_BITS = $clog2(NUM_WARPS),
   localparam int DATA_W       = NUM_LANES * ARCH_LEN,
   localparam int PTR_W        = $clog2(DEPTH),
   localparam int CNT_W        = PTR_W + 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ARCH_LEN-1:0]     in_pc,
   input  logic [WARP_ID_BITS-1:0] in_warpId,
   input  logic                    in_wen,
   input  logic [REG_BITS-1:0]     in_rd,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_last,
   output logic                    trace_valid,
   output logic [ARCH_LEN-1:0]     trace_pc,
   output logic [WARP_ID_BITS-1:0] trace_warpId,
   output logic                    trace_regs_0_enable,
   output logic [REG_BITS-1:0]     trace_regs_0_address,
   output logic [DATA_W-1:0]       trace_regs_0_data,
   output logic                    trace_regs_1_enable,
   output logic [REG_BITS-1:0]     trace_regs_1_address,
   output logic [DATA_W-1:0]       trace_regs_1_data,
   output logic                    trace_regs_2_enable,
   output logic [REG_BITS-1:0]     trace_regs_2_address,
   output logic [DATA_W-1:0]       trace_regs_2_data,
   output logic [1:0]              err,
   output logic                    idle
`ifdef REGTRACE_STALL_CNT_EN
   ,
   output logic [31:0]             stall_cnt,
   output logic [CNT_W-1:0]        max_occupancy
`endif
);

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   typedef struct packed {
      logic [ARCH_LEN-1:0]         pc;
      logic [WARP_ID_BITS-1:0]     warp;
      logic [2:0]                  en;
      logic [2:0][REG_BITS-1:0]    addr;
      logic [2:0][DATA_W-1:0]      data;
   } rec_t;

   state_t            state_q, state_d;
   rec_t              part_q, merged;
   logic [1:0]        slot_cnt_q, cnt_base, cnt_merged;
   rec_t              mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   rec_t              out_q;
   logic              out_valid_q, out_valid_d;
   logic [1:0]        err_q;
   logic              idle_q;

   logic full, accept, wr_slot, overflow, mismatch, push, pop, bypass, fifo_wr;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign in_ready = !full;
   assign accept   = in_valid && in_ready && !flush;
   assign wr_slot  = in_wen && (in_rd != '0);
   assign mismatch = (state_q == S_ACCUM) && ((in_pc != part_q.pc) || (in_warpId != part_q.warp));
   assign push     = accept && in_last;
   assign pop      = (count_q != '0);
   // An empty FIFO lets a completed record go straight to the output stage.
   assign bypass   = push && (count_q == '0);
   assign fifo_wr  = push && !bypass;
   assign count_d  = count_q + CNT_W'(fifo_wr) - CNT_W'(pop);
   assign out_valid_d = pop || bypass;

   always_comb begin
      merged   = (state_q == S_ACCUM) ? part_q : '0;
      cnt_base = (state_q == S_ACCUM) ? slot_cnt_q : 2'd0;
      if (state_q == S_IDLE) begin
         merged.pc   = in_pc;
         merged.warp = in_warpId;
      end
      cnt_merged = cnt_base;
      overflow   = 1'b0;
      if (wr_slot) begin
         if (cnt_base == 2'd3) overflow = 1'b1;
         else                  cnt_merged = cnt_base + 2'd1;
      end
      for (int s = 0; s < 3; s++) begin
         if (wr_slot && (cnt_base == 2'(s))) begin
            merged.en[s]   = 1'b1;
            merged.addr[s] = in_rd;
            merged.data[s] = in_data;
         end
      end
      state_d = state_q;
      if (flush)       state_d = S_IDLE;
      else if (accept) state_d = in_last ? S_IDLE : S_ACCUM;
   end

   always_ff @(posedge clock) begin
      if (fifo_wr) mem[wr_ptr_q] <= merged;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         part_q      <= '0;
         slot_cnt_q  <= 2'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 2'b00;
         idle_q      <= 1'b1;
      end else begin
         state_q <= state_d;
         if (flush || (accept && in_last)) begin
            part_q     <= '0;
            slot_cnt_q <= 2'd0;
         end else if (accept) begin
            part_q     <= merged;
            slot_cnt_q <= cnt_merged;
         end
         err_q <= err_q | {accept && mismatch, accept && overflow};
         if (fifo_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         if (pop)         out_q <= mem[rd_ptr_q];
         else if (bypass) out_q <= merged;
         else             out_q <= '0;
         out_valid_q <= out_valid_d;
         idle_q      <= (count_d == '0) && (state_d == S_IDLE) && !out_valid_d;
      end
   end

   assign trace_valid          = out_valid_q;
   assign trace_pc             = out_q.pc;
   assign trace_warpId         = out_q.warp;
   assign trace_regs_0_enable  = out_q.en[0];
   assign trace_regs_0_address = out_q.addr[0];
   assign trace_regs_0_data    = out_q.data[0];
   assign trace_regs_1_enable  = out_q.en[1];
   assign trace_regs_1_address = out_q.addr[1];
   assign trace_regs_1_data    = out_q.data[1];
   assign trace_regs_2_enable  = out_q.en[2];
   assign trace_regs_2_address = out_q.addr[2];
   assign trace_regs_2_data    = out_q.data[2];
   assign err                  = err_q;
   assign idle                 = idle_q;

`ifdef REGTRACE_STALL_CNT_EN
   logic [31:0]      stall_q;
   logic [CNT_W-1:0] max_occ_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_q   <= '0;
         max_occ_q <= '0;
      end else begin
         if (in_valid && !in_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
         if (count_d > max_occ_q) max_occ_q <= count_d;
      end
   end

   assign stall_cnt     = stall_q;
   assign max_occupancy = max_occ_q;
`endif

endmodule

// File: doc/regtrace_collector.md
Name: regtrace_collector

Overview:
- Produces the per-cycle register-writeback trace that the Cyclotron difftest checker consumes: valid, pc, warpId and three register write slots.
- Sits between the core's commit/writeback stage and the difftest sink.
- Accepts multi-beat commit records from the pipeline, one register write per beat, and packs each instruction's writes into a single trace record.
- Buffers records in a FIFO and drains them at one per cycle.

Parameters:
ARCH_LEN, 32, bits per lane register value
NUM_WARPS, 8, warp count; WARP_ID_BITS = $clog2(NUM_WARPS)
NUM_LANES, 16, lanes per register write
REG_BITS, 8, register address width
DEPTH, 4, record FIFO entries (power of 2, >=2)

Ports:
clock  in  1  sole clock
reset_n  in  1  reset; asynchronous, active-low
flush  in  1  synchronous discard of the partial (unfinished) record
in_valid  in  1  commit beat valid
in_ready  out  1  beat accepted when in_valid&&in_ready
in_pc  in  ARCH_LEN  instruction pc
in_warpId  in  WARP_ID_BITS  issuing warp
in_wen  in  1  beat carries a register write
in_rd  in  REG_BITS  destination register
in_data  in  NUM_LANES*ARCH_LEN  lane data, lane g at [ARCH_LEN*g +: ARCH_LEN]
in_last  in  1  final beat of instruction
trace_valid  out  1  one record presented this cycle
trace_pc  out  ARCH_LEN  record pc
trace_warpId  out  WARP_ID_BITS  record warp
trace_regs_{0,1,2}_enable  out  1  slot holds a write
trace_regs_{0,1,2}_address  out  REG_BITS  slot register
trace_regs_{0,1,2}_data  out  NUM_LANES*ARCH_LEN  slot data
err  out  2  sticky; [0] slot overflow, [1] pc/warp mismatch within record
idle  out  1  FIFO empty and no partial record

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0): all outputs 0 except in_ready=1 and idle=1; FIFO empty; assembler IDLE; slot count 0; err=0. Asserting reset mid-record discards the partial record and all FIFO contents.
- Assembler states:
  - IDLE: no partial record.
  - ACCUM: a partial record exists, holding 0..3 filled slots.
- in_ready = !fifo_full, using the registered count. A same-cycle pop does not free space for a same-cycle push.
- Accepted beat in IDLE: latch in_pc/in_warpId.
  - in_last=0 -> ACCUM.
  - in_last=1 -> enqueue immediately; stay IDLE.
- Accepted beat in ACCUM: in_pc/in_warpId must equal the latched values. On mismatch, set err[1]; the latched values are kept.
- Slot fill:
  - A beat with in_wen=1 and in_rd!=0 fills the next free slot in order 0,1,2: enable=1, address=in_rd, data=in_data.
  - A beat with in_wen=0 or in_rd==0 fills no slot.
  - A fourth write sets err[0]; that write is dropped and the record is otherwise preserved.
- in_last=1 enqueues the completed record, including this beat's write, in the same cycle. Unfilled slots are enqueued with enable=0, address=0, data=0. Then -> IDLE.
- Single beat with in_wen=0, in_last=1: a record with all enables 0 (e.g. store, branch).
- flush=1: partial record discarded, -> IDLE, slot count 0; FIFO untouched. If flush coincides with an accepted beat, flush wins and the beat is dropped entirely, even when in_last=1.
- Drain:
  - Registered output stage. When the FIFO is non-empty, the head is popped and presented on trace_* for exactly one cycle with trace_valid=1; there is no sink backpressure.
  - When the FIFO is empty: trace_valid=0 and all trace_* fields are 0.
- Latency: last beat accepted at cycle N with an empty FIFO -> trace_valid=1 at N+1.
- Throughput: one record per cycle. Back-to-back single-beat commits sustain trace_valid=1 every cycle with the FIFO never filling.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits; full is count==DEPTH.
- Simultaneous push and pop: count unchanged.
- idle is registered: 1 when count==0, the assembler is IDLE and the output stage is empty.

Optional Feature:
- Macro: REGTRACE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 32 bits, reset 0.
  - Increments each cycle with in_valid&&!in_ready; saturates at 0xFFFFFFFF.
  - Adds output max_occupancy, log2(DEPTH)+1 bits, reset 0, recording the peak FIFO count.
- Undefined: neither port exists and no counter logic is synthesized; all other behaviour is identical.

Test Plan:
- Reset, then one beat: pc=0x80000000, warp=3, wen=1, rd=5, data all lanes 0xDEADBEEF, last=1 -> next cycle trace_valid=1, pc=0x80000000, warpId=3, regs_0 enable=1/address=5/data all lanes 0xDEADBEEF, regs_1/2 enable=0; following cycle trace_valid=0, idle=1.
- Three beats for pc=0x100: rd=1,2,3 with last on the third -> single record with slots 0/1/2 = rd 1/2/3; a fourth-write variant sets err[0]=1 and slots stay rd 1/2/3.
- Beat with rd=0, wen=1, last=1 -> record with all enables 0, err=0.
- Hold the sink full by issuing DEPTH+2 single-beat commits in consecutive cycles while the FIFO drains -> in_ready never drops, trace_valid high for DEPTH+2 consecutive cycles. Then force a 2-beat mismatch (second beat pc=0x104 vs 0x100) -> err[1]=1, record pc=0x100.
- Partial record (one non-last beat rd=7), then flush, then a beat rd=9 with last -> only one record out, slot 0 rd=9.
- Assert reset_n low asynchronously mid-record with 2 records queued -> outputs 0 immediately, no records emitted after release, idle=1.
